// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - token encodings, key map and state enums shared by the keypad tokenizer.
package keypad_pkg;

  localparam logic [3:0] TOK_ADD = 4'hA;
  localparam logic [3:0] TOK_SUB = 4'hB;
  localparam logic [3:0] TOK_MUL = 4'hC;
  localparam logic [3:0] TOK_DIV = 4'hD;
  localparam logic [3:0] TOK_EQ  = 4'hE;
  localparam logic [3:0] TOK_CLR = 4'hF;

  // Nibble i holds the token for key index i = {row, col}; index 0 (row 0, col 0) is the LSB nibble.
  localparam logic [63:0] KEY_MAP = {
    TOK_DIV, TOK_EQ, 4'h0, TOK_CLR,
    TOK_MUL, 4'h9,   4'h8, 4'h7,
    TOK_SUB, 4'h6,   4'h5, 4'h4,
    TOK_ADD, 4'h3,   4'h2, 4'h1
  };

  typedef enum logic [1:0] {DEB_IDLE, DEB_CAND, DEB_HELD, DEB_REL} deb_state_e;
  typedef enum logic [1:0] {SWEEP_NONE, SWEEP_KEY, SWEEP_MULTI} sweep_e;

  function automatic logic [3:0] key_token(input logic [3:0] key_idx);
    return KEY_MAP[{key_idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/token_fifo.sv
// rtl/token_fifo.sv - synchronous token FIFO; a push while full is accepted only if a pop happens in the same cycle.
module token_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_tokenizer.sv
// rtl/keypad_tokenizer.sv - 4x4 keypad scanner, sweep debouncer and ready-gated token issue.
// Optional KEYPAD_AUTO_CLEAR_EN: strobe a clear token before the first operand after reset or '='.
module keypad_tokenizer import keypad_pkg::*; #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  input  logic       ready,
  output logic       strobe,
  output logic [3:0] token,
  output logic       overflow
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [SW-1:0] slot_q;
  logic [1:0]    col_q;
  logic [1:0]    hits_q;
  logic [3:0]    pos_q;
  logic          slot_end, sweep_end;
  logic [3:0]    pressed;
  logic [2:0]    col_cnt, total;
  logic [1:0]    col_row;
  logic [3:0]    sweep_key;
  sweep_e        sweep_kind;

  assign slot_end  = (slot_q == SW'(SCAN_DIV - 1));
  assign sweep_end = slot_end & (col_q == 2'd3);
  assign col_out   = ~(4'b0001 << col_q);
  assign pressed   = ~row_in;

  always_comb begin
    col_cnt = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
    col_row = 2'd0;
    if (pressed[0])      col_row = 2'd0;
    else if (pressed[1]) col_row = 2'd1;
    else if (pressed[2]) col_row = 2'd2;
    else if (pressed[3]) col_row = 2'd3;
    total     = {1'b0, hits_q} + col_cnt;
    sweep_key = (hits_q == 2'd0) ? {col_row, col_q} : pos_q;
    if (total == 3'd0)      sweep_kind = SWEEP_NONE;
    else if (total == 3'd1) sweep_kind = SWEEP_KEY;
    else                    sweep_kind = SWEEP_MULTI;
  end

  // Hit count saturates at 2: anything beyond one intersection is already MULTI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      col_q  <= 2'd0;
      hits_q <= 2'd0;
      pos_q  <= 4'd0;
    end else if (slot_end) begin
      slot_q <= '0;
      col_q  <= col_q + 2'd1;
      hits_q <= sweep_end ? 2'd0 : ((total > 3'd2) ? 2'd2 : total[1:0]);
      pos_q  <= sweep_end ? 4'd0 : sweep_key;
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  deb_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    key_q, key_d;
  logic          push;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    key_d = key_q;
    push  = 1'b0;
    if (sweep_end) begin
      case (st_q)
        DEB_IDLE: if (sweep_kind == SWEEP_KEY) begin
          key_d = sweep_key;
          cnt_d = CW'(1);
          push  = (DEBOUNCE == 1);
          st_d  = (DEBOUNCE == 1) ? DEB_HELD : DEB_CAND;
        end
        DEB_CAND: if (sweep_kind == SWEEP_KEY && sweep_key == key_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE)) begin
            push = 1'b1;
            st_d = DEB_HELD;
          end
        end else begin
          st_d = DEB_IDLE;
        end
        DEB_HELD: if (sweep_kind == SWEEP_NONE) begin
          cnt_d = CW'(1);
          st_d  = (DEBOUNCE == 1) ? DEB_IDLE : DEB_REL;
        end
        DEB_REL: if (sweep_kind == SWEEP_NONE) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE)) st_d = DEB_IDLE;
        end else begin
          st_d = DEB_HELD;
        end
        default: st_d = DEB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= DEB_IDLE;
      cnt_q <= '0;
      key_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  logic [3:0] head, issue_tok;
  logic       full, empty, pop_q, strobe_q, strobe_d, issue_pop, overflow_q;
  logic [3:0] token_q;

  token_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_q),
    .din   (key_token(sweep_key)),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign strobe_d = ready & ~empty & ~strobe_q;

`ifdef KEYPAD_AUTO_CLEAR_EN
  logic need_clr_q, insert_clr;
  // The inserted clear is synthesised here, so the head stays in the FIFO until its own strobe.
  assign insert_clr = need_clr_q & (head != TOK_CLR);
  assign issue_tok  = insert_clr ? TOK_CLR : head;
  assign issue_pop  = ~insert_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_clr_q <= 1'b1;
    end else if (strobe_d) begin
      if (issue_tok == TOK_EQ)       need_clr_q <= 1'b1;
      else if (issue_tok == TOK_CLR) need_clr_q <= 1'b0;
    end
  end
`else
  assign issue_tok = head;
  assign issue_pop = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q   <= 1'b0;
      pop_q      <= 1'b0;
      token_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      pop_q    <= strobe_d & issue_pop;
      if (strobe_d) token_q <= issue_tok;
      if (push & full & ~pop_q) overflow_q <= 1'b1;
    end
  end

  assign strobe   = strobe_q;
  assign token    = token_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_tokenizer.sv
// tb/tb_keypad_tokenizer.sv - randomized keypad episodes against a sweep-level press/release model with a token scoreboard.
module tb_keypad_tokenizer;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in, col_out, token;
  logic        ready = 1'b0;
  logic        strobe, overflow;
  logic [15:0] keys = '0;

  int errors = 0;
  int checks = 0;
  int cyc;
  bit latched = 0;
  bit need_clr_m = 1;
  bit rnd_ready = 0;
  int tb_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  // Passive keypad: a row reads low when a pressed key joins it to the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  keypad_tokenizer #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .ready    (ready),
    .strobe   (strobe),
    .token    (token),
    .overflow (overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void emit(input int tok);
`ifdef KEYPAD_AUTO_CLEAR_EN
    if (need_clr_m && tok != 15) exp_q.push_back(4'hF);
    if (tok == 14) need_clr_m = 1;
    else if (tok == 15) need_clr_m = 0;
`endif
    exp_q.push_back(4'(tok));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    bit prev_strobe = 0;
    bit prev_ready = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("col_out", int'(col_out), int'(4'hF ^ (4'h1 << ((cyc / SCAN_DIV) % 4))));
        if (strobe) begin
          check("strobe_gap", int'(prev_strobe), 0);
          check("strobe_ready", int'(prev_ready), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe_token", int'(token), -1);
          end else begin
            check("token", int'(token), int'(exp_q.pop_front()));
          end
        end
        prev_strobe = strobe;
        prev_ready  = ready;
      end else begin
        prev_strobe = 0;
        prev_ready  = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached with %0d tokens outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic sweeps(input int n);
    repeat (n * SWEEP) @(posedge clk);
    #1;
  endtask

  task automatic reset_values();
    check("rst_col_out", int'(col_out), 4'hE);
    check("rst_strobe", int'(strobe), 0);
    check("rst_token", int'(token), 0);
    check("rst_overflow", int'(overflow), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    latched = 0;
    need_clr_m = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    keys = '0;
    model_reset();
    #1;
    reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One stable press of n sweeps followed by m released sweeps; the token decision is made before pressing.
  task automatic episode(input logic [15:0] mask, input int n, input int m);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
    if ($countones(mask) == 1 && !latched && n >= DEB) begin
      emit(tb_map[idx]);
      latched = 1;
    end
    keys = mask;
    sweeps(n);
    keys = '0;
    if (m > 0) sweeps(m);
    if (m >= DEB) latched = 0;
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    check("drain_outstanding", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    ready = 1'b1;

    episode(16'h1 << 6, 3, 3);
    wait_drain(200);

    episode(16'h1 << 15, 1, 1);
    episode(16'h1 << 15, 2, DEB);
    wait_drain(200);

    episode(16'h0003, 3, 0);
    episode(16'h0001, 3, DEB);
    wait_drain(200);

    rnd_ready = 1;
    for (int e = 0; e < 50; e++) begin
      int a = $urandom_range(0, 15);
      int b = (a + $urandom_range(1, 15)) % 16;
      if ($urandom_range(0, 3) == 0)
        episode((16'h1 << a) | (16'h1 << b), $urandom_range(1, DEB + 2), $urandom_range(0, DEB + 2));
      else
        episode(16'h1 << a, $urandom_range(1, DEB + 2), $urandom_range(1, DEB + 2));
    end
    keys = '0;
    sweeps(DEB);
    latched = 0;
    rnd_ready = 0;
    ready = 1'b1;
    wait_drain(2000);
    check("no_overflow_random", int'(overflow), 0);

    ready = 1'b0;
    episode(16'h1 << 0, DEB, DEB);
    episode(16'h1 << 1, DEB, DEB);
    episode(16'h1 << 2, DEB, DEB);
    episode(16'h1 << 4, DEB, DEB);
    episode(16'h1 << 5, DEB, DEB);
    void'(exp_q.pop_back());
    check("overflow_set", int'(overflow), 1);
    check("held_no_strobe", int'(strobe), 0);
    ready = 1'b1;
    wait_drain(200);
    check("overflow_sticky", int'(overflow), 1);

    ready = 1'b0;
    emit(tb_map[9]);
    latched = 1;
    keys = 16'h1 << 9;
    sweeps(DEB + 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_strobe", int'(strobe), 1);
    check("pre_reset_token", int'(token), int'(exp_q[0]));
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    episode(16'h1 << 9, DEB + 1, DEB);
    wait_drain(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
